// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared fetch state encodings and defaults
package instr_fetch_ctrl_pkg;

   // State encodings are shared with the decode stage, so keep the values fixed
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

   localparam int DEFAULT_WIDTH   = 16;
   localparam int DEFAULT_TIMEOUT = 15;

   // Wide enough for any TIMEOUT in 1..255
   localparam int TIMER_BITS = 8;

endpackage

// File: rtl/instr_fetch_ctrl_fetch_timer.sv
// rtl/instr_fetch_ctrl_fetch_timer.sv - bounded wait counter for ROM acknowledge
module fetch_timer
   import instr_fetch_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMER_BITS-1:0] LAST = TIMER_BITS'(TIMEOUT - 1);

   logic [TIMER_BITS-1:0] count;

   // expired marks the last allowed waiting cycle, not the one after it
   assign expired = (count == LAST);

   // Count waiting cycles; saturate at the last value so it never wraps
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch sequencer between PC, instruction ROM and decode
module instr_fetch_ctrl
   import instr_fetch_ctrl_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc_value,
   output logic             pc_reset,
   output logic             pc_inc,
   output logic             pc_load,
   output logic [WIDTH-1:0] pc_d,
   output logic             rom_req,
   output logic [WIDTH-1:0] rom_addr,
   input  logic             rom_ack,
   input  logic [WIDTH-1:0] rom_data,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [WIDTH-1:0] instr,
   input  logic             jump_valid,
   input  logic [WIDTH-1:0] jump_target,
   output logic             fault,
   output logic [WIDTH-1:0] fetch_count
);

   fetch_state_t state;

   logic in_fetch;
   logic handshake;
   logic timer_clear;
   logic timer_enable;
   logic timer_expired;

   assign in_fetch  = (state == ST_FETCH);
   assign handshake = (state == ST_HOLD) && instr_ready;

   // PC controls are combinational so the PC moves on the same edge as the state change
   assign pc_inc  = in_fetch && rom_ack;
   assign pc_load = handshake && jump_valid;
   assign pc_d    = pc_load ? jump_target : '0;

   // rom_req is registered and high exactly while in FETCH
   assign rom_addr = rom_req ? pc_value : '0;

   // The timer only runs across consecutive un-acked FETCH cycles
   assign timer_clear  = !in_fetch || rom_ack;
   assign timer_enable = in_fetch && !rom_ack;

   fetch_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   // Fetch FSM with registered Moore outputs, instruction register and delivery count
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_BOOT;
         pc_reset    <= 1'b0;
         rom_req     <= 1'b0;
         instr_valid <= 1'b0;
         fault       <= 1'b0;
         instr       <= '0;
         fetch_count <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               // First edge raises pc_reset, second edge leaves BOOT with the PC cleared
               if (!pc_reset) begin
                  pc_reset <= 1'b1;
               end else begin
                  pc_reset <= 1'b0;
                  rom_req  <= 1'b1;
                  state    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (rom_ack) begin
                  instr       <= rom_data;
                  rom_req     <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= ST_HOLD;
               end else if (timer_expired) begin
                  rom_req <= 1'b0;
                  fault   <= 1'b1;
                  state   <= ST_FAULT;
               end
            end
            ST_HOLD: begin
               if (instr_ready) begin
                  fetch_count <= fetch_count + 1'b1;
                  instr_valid <= 1'b0;
                  rom_req     <= 1'b1;
                  state       <= ST_FETCH;
               end
            end
            ST_FAULT: begin
               // Sticky until reset
               state <= ST_FAULT;
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

   // The PC must never be asked to increment and load at once
   a_inc_load_exclusive: assert property (@(posedge clock) disable iff (!reset)
      !(pc_inc && pc_load));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed bench with PC and variable-latency ROM models
module tb_instr_fetch_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] pc_q;
   logic        pc_reset, pc_inc, pc_load;
   logic [15:0] pc_d;
   logic        rom_req;
   logic [15:0] rom_addr;
   logic        rom_ack;
   logic [15:0] rom_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        jump_valid;
   logic [15:0] jump_target;
   logic        fault;
   logic [15:0] fetch_count;

   logic [7:0]  rom_lat;
   logic        rom_never;
   logic [7:0]  rom_wait;
   logic        model_ack;
   logic        force_ack;
   logic [15:0] force_data;

   int n_checks = 0;
   int n_fail   = 0;
   int n;

   always #5 clock = ~clock;

   instr_fetch_ctrl #(.WIDTH(16), .TIMEOUT(15)) dut (
      .clock       (clock),
      .reset       (reset),
      .pc_value    (pc_q),
      .pc_reset    (pc_reset),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .pc_d        (pc_d),
      .rom_req     (rom_req),
      .rom_addr    (rom_addr),
      .rom_ack     (rom_ack),
      .rom_data    (rom_data),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .jump_valid  (jump_valid),
      .jump_target (jump_target),
      .fault       (fault),
      .fetch_count (fetch_count)
   );

   // PC model
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       pc_q <= '0;
      else if (pc_reset) pc_q <= '0;
      else if (pc_load)  pc_q <= pc_d;
      else if (pc_inc)   pc_q <= pc_q + 16'd1;
   end

   // ROM model: acks after rom_lat extra request cycles, ROM[n] = n + 0x100
   assign model_ack = rom_req && !rom_never && (rom_wait == rom_lat);
   assign rom_ack   = model_ack || force_ack;
   assign rom_data  = force_ack ? force_data : (rom_addr + 16'h0100);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                    rom_wait <= '0;
      else if (rom_req && !model_ack) rom_wait <= rom_wait + 8'd1;
      else                           rom_wait <= '0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Steps to the next negedge until instr_valid, returning cycles taken
   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while (!instr_valid && cycles < 40);
      check("wait_valid_timeout", 32'(instr_valid), 32'd1);
   endtask

   initial begin
      reset = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0; jump_target = '0;
      rom_lat = 8'd1; rom_never = 1'b0; force_ack = 1'b0; force_data = '0;

      // 1: reset and boot
      repeat (3) @(negedge clock);
      check("rst_pc_reset", 32'(pc_reset), 32'd0);
      check("rst_rom_req", 32'(rom_req), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_fetch_count", 32'(fetch_count), 32'd0);
      reset = 1'b1; instr_ready = 1'b1;
      @(negedge clock);
      check("boot_pc_reset", 32'(pc_reset), 32'd1);
      check("boot_rom_req", 32'(rom_req), 32'd0);
      @(negedge clock);
      check("fetch_pc_reset", 32'(pc_reset), 32'd0);
      check("fetch_rom_req", 32'(rom_req), 32'd1);
      check("fetch_rom_addr", 32'(rom_addr), 32'h0);

      // 2: streaming with one-cycle ROM latency
      wait_valid(n);
      check("seq0_instr", 32'(instr), 32'h100);
      check("seq0_count", 32'(fetch_count), 32'd0);
      wait_valid(n);
      check("seq1_cycles", 32'(n), 32'd3);
      check("seq1_instr", 32'(instr), 32'h101);
      check("seq1_count", 32'(fetch_count), 32'd1);
      wait_valid(n);
      check("seq2_cycles", 32'(n), 32'd3);
      check("seq2_instr", 32'(instr), 32'h102);
      check("seq2_count", 32'(fetch_count), 32'd2);

      // 3: downstream stall
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("hold_valid", 32'(instr_valid), 32'd1);
         check("hold_instr", 32'(instr), 32'h102);
         check("hold_rom_req", 32'(rom_req), 32'd0);
         check("hold_pc", 32'(pc_q), 32'd3);
         check("hold_pc_inc", 32'(pc_inc), 32'd0);
      end

      // 4: jump ignored without handshake, taken with it
      jump_valid = 1'b1; jump_target = 16'h0040;
      #1;
      check("nojump_pc_load", 32'(pc_load), 32'd0);
      check("nojump_pc_d", 32'(pc_d), 32'd0);
      instr_ready = 1'b1;
      #1;
      check("jump_pc_load", 32'(pc_load), 32'd1);
      check("jump_pc_d", 32'(pc_d), 32'h40);
      check("jump_pc_inc", 32'(pc_inc), 32'd0);
      @(negedge clock);
      jump_valid = 1'b0;
      check("jump_rom_addr", 32'(rom_addr), 32'h40);
      check("jump_count", 32'(fetch_count), 32'd3);
      check("jump_valid_low", 32'(instr_valid), 32'd0);
      wait_valid(n);
      check("jump_instr", 32'(instr), 32'h140);

      // 5: ROM never acks
      rom_never = 1'b1;
      @(negedge clock);
      n = 0;
      for (int g = 0; g < 40 && !fault; g++) begin
         if (rom_req) n++;
         @(negedge clock);
      end
      check("to_fetch_cycles", 32'(n), 32'd15);
      check("to_fault", 32'(fault), 32'd1);
      check("to_rom_req", 32'(rom_req), 32'd0);
      check("to_valid", 32'(instr_valid), 32'd0);
      check("to_count", 32'(fetch_count), 32'd4);
      force_ack = 1'b1; force_data = 16'hBEEF;
      #1;
      check("fault_pc_inc", 32'(pc_inc), 32'd0);
      repeat (2) @(negedge clock);
      check("fault_sticky", 32'(fault), 32'd1);
      check("fault_instr", 32'(instr), 32'h140);
      check("fault_pc", 32'(pc_q), 32'h41);
      force_ack = 1'b0;
      reset = 1'b0;
      #1;
      check("clr_fault", 32'(fault), 32'd0);
      check("clr_instr", 32'(instr), 32'd0);
      check("clr_count", 32'(fetch_count), 32'd0);

      // 6: reset in the middle of a pending fetch, stale ack after release
      rom_never = 1'b0; rom_lat = 8'd3;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("mid_rom_req", 32'(rom_req), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("mid_rst_rom_req", 32'(rom_req), 32'd0);
      check("mid_rst_valid", 32'(instr_valid), 32'd0);
      force_ack = 1'b1; force_data = 16'hDEAD;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("stale_pc_reset", 32'(pc_reset), 32'd1);
      check("stale_instr", 32'(instr), 32'd0);
      check("stale_valid", 32'(instr_valid), 32'd0);
      @(posedge clock);
      #1 force_ack = 1'b0;
      check("restart_addr", 32'(rom_addr), 32'h0);
      wait_valid(n);
      check("restart_instr", 32'(instr), 32'h100);
      check("restart_count", 32'(fetch_count), 32'd0);
      check("restart_pc", 32'(pc_q), 32'd1);

      // Zero-latency ROM gives two cycles per instruction
      rom_lat = 8'd0;
      wait_valid(n);
      check("lat0_cycles", 32'(n), 32'd2);
      check("lat0_instr", 32'(instr), 32'h101);
      check("lat0_count", 32'(fetch_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
